brief_desc_packer: RTL and testbench

// - Downstream of the BRIEF stage: captures each finished descriptor (PNUM-bit string plus keypoint x/y) on the written pulse.
// - Buffers descriptors in a small FIFO; emits each as a valid/ready word stream (header + PNUM/WORDW payload words) to the frame-store/host writer.
// - Decouples single-cycle written pulses from a back-pressured output bus; drops and counts descriptors on overflow.

---
 rtl/brief_desc_packer.sv | 185 ++++++++++++++++++
 tb/tb_brief_desc_packer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/brief_desc_packer.sv
// Buffers finished BRIEF descriptors and streams each as header + payload words on a valid/ready bus.
// Optional DESC_CHECKSUM_EN appends an XOR-of-payload word that carries out_last.
module brief_desc_packer #(
   parameter int PNUM  = 256,
   parameter int WORDW = 32,
   parameter int DEPTH = 4,
   parameter int XYW   = 11
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     written,
   input  logic [XYW-1:0]           x,
   input  logic [XYW-1:0]           y,
   input  logic [PNUM-1:0]          binary_string,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WORDW-1:0]         out_data,
   output logic                     out_last,
   output logic                     overflow,
   output logic [15:0]              drop_cnt,
   output logic [$clog2(DEPTH):0]   fifo_level
);
   localparam int NW   = PNUM / WORDW;
   localparam int IDXW = (NW > 1) ? $clog2(NW) : 1;
   localparam int PW   = $clog2(DEPTH);
   localparam int LW   = PW + 1;
   localparam int MW   = 10 + 2 * XYW;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NW - 1);
   localparam logic [LW-1:0]   FULL_LVL = LW'(DEPTH);
`ifdef DESC_CHECKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, HDR, PAY, CHK} state_t;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              out_valid_q, out_valid_d;
   logic [WORDW-1:0]  out_data_q, out_data_d;
   logic              out_last_q, out_last_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic [9:0]        seq_q, seq_d;
   logic              overflow_q, overflow_d;
   logic [15:0]       drop_cnt_q, drop_cnt_d;

   logic [PNUM-1:0]   mem_str  [DEPTH];
   logic [MW-1:0]     mem_meta [DEPTH];
   logic [WORDW-1:0]  head_words [NW];
   logic [MW-1:0]     head_meta, next_meta;
   logic              hs, pop, push_acc, drop, more_after_pop;

   function automatic logic [WORDW-1:0] hdr_word(input logic [MW-1:0] m);
      hdr_word = '0;
      hdr_word[MW-1:0] = m;
   endfunction

   for (genvar gi = 0; gi < NW; gi++) begin : g_words
      assign head_words[gi] = mem_str[rd_ptr_q][gi*WORDW +: WORDW];
   end

`ifdef DESC_CHECKSUM_EN
   logic [WORDW-1:0] chk_word;
   always_comb begin
      chk_word = '0;
      for (int i = 0; i < NW; i++) chk_word = chk_word ^ head_words[i];
   end
   assign pop = hs && (state_q == CHK);
`else
   assign pop = hs && (state_q == PAY) && (idx_q == LAST_IDX);
`endif

   assign hs       = out_valid_q && out_ready;
   assign push_acc = written && !rst && ((level_q != FULL_LVL) || pop);
   assign drop     = written && !rst && !push_acc;
   assign head_meta = mem_meta[rd_ptr_q];
   // With a single stored entry, the successor is the one being pushed right now.
   assign next_meta = (level_q > LW'(1)) ? mem_meta[rd_ptr_q + PW'(1)] : {seq_q, y, x};
   assign more_after_pop = (level_q > LW'(1)) || push_acc;

   always_comb begin
      wr_ptr_d   = push_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      seq_d      = push_acc ? seq_q + 10'd1 : seq_q;
      level_d    = level_q;
      if (push_acc && !pop)      level_d = level_q + LW'(1);
      else if (!push_acc && pop) level_d = level_q - LW'(1);
      overflow_d = overflow_q || drop;
      drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      if (pop) begin
         out_last_d = 1'b0;
         if (more_after_pop) begin
            state_d    = HDR;
            out_data_d = hdr_word(next_meta);
         end else begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_data_d  = '0;
         end
      end else begin
         case (state_q)
            IDLE: if (level_q != '0) begin
               state_d     = HDR;
               out_valid_d = 1'b1;
               out_data_d  = hdr_word(head_meta);
               out_last_d  = 1'b0;
            end
            HDR: if (hs) begin
               state_d    = PAY;
               idx_d      = '0;
               out_data_d = head_words[0];
               out_last_d = !CHK_EN && (LAST_IDX == '0);
            end
            PAY: begin
               if (hs && idx_q != LAST_IDX) begin
                  idx_d      = idx_q + IDXW'(1);
                  out_data_d = head_words[idx_d];
                  out_last_d = !CHK_EN && (idx_d == LAST_IDX);
               end
`ifdef DESC_CHECKSUM_EN
               else if (hs) begin
                  state_d    = CHK;
                  out_data_d = chk_word;
                  out_last_d = 1'b1;
               end
`endif
            end
            default: ;
         endcase
      end
   end

   // Storage carries no reset so it can map onto RAM; validity comes from the pointers.
   always_ff @(posedge clk) begin
      if (push_acc) begin
         mem_str[wr_ptr_q]  <= binary_string;
         mem_meta[wr_ptr_q] <= {seq_q, y, x};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         level_q     <= '0;
         seq_q       <= '0;
         overflow_q  <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         level_q     <= level_d;
         seq_q       <= seq_d;
         overflow_q  <= overflow_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_last   = out_last_q;
   assign overflow   = overflow_q;
   assign drop_cnt   = drop_cnt_q;
   assign fifo_level = level_q;
endmodule

// File: tb/tb_brief_desc_packer.sv
// Directed bench for brief_desc_packer: single, back-pressure, overflow, full+pop, reset mid-stream.
module tb_brief_desc_packer;
   localparam int NW = 8;
`ifdef DESC_CHECKSUM_EN
   localparam int F = NW + 2;
`else
   localparam int F = NW + 1;
`endif

   logic          clk = 1'b0;
   logic          rst, written, out_valid, out_ready, out_last, overflow;
   logic [10:0]   x, y;
   logic [255:0]  binary_string;
   logic [31:0]   out_data;
   logic [15:0]   drop_cnt;
   logic [2:0]    fifo_level;

   int checks = 0;
   int errors = 0;
   int seq_m  = 0;
   logic [32:0] exp_q[$];

   brief_desc_packer dut (
      .clk(clk), .rst(rst), .written(written), .x(x), .y(y),
      .binary_string(binary_string), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .overflow(overflow),
      .drop_cnt(drop_cnt), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [255:0] mk_str(input int base);
      logic [255:0] s;
      for (int j = 0; j < NW; j++) s[j*32 +: 32] = 32'(base) * 32'h01010101 + 32'(j * 7);
      return s;
   endfunction

   task automatic model_push(input logic [10:0] px, input logic [10:0] py, input logic [255:0] s);
      logic [9:0]  sq;
      logic [31:0] c;
      sq = 10'(seq_m);
      c  = '0;
      exp_q.push_back({1'b0, sq, py, px});
      for (int j = 0; j < NW; j++) begin
         c = c ^ s[j*32 +: 32];
`ifdef DESC_CHECKSUM_EN
         exp_q.push_back({1'b0, s[j*32 +: 32]});
`else
         exp_q.push_back({j == NW - 1, s[j*32 +: 32]});
`endif
      end
`ifdef DESC_CHECKSUM_EN
      exp_q.push_back({1'b1, c});
`endif
      seq_m = (seq_m + 1) % 1024;
   endtask

   task automatic push_desc(input logic [10:0] px, input logic [10:0] py, input logic [255:0] s,
                            input bit accept);
      x = px; y = py; binary_string = s; written = 1'b1;
      tick();
      written = 1'b0;
      if (accept) model_push(px, py, s);
   endtask

   task automatic drain(input int n);
      int got = 0;
      int cyc = 0;
      out_ready = 1'b1;
      while (got < n && cyc < n * 4 + 20) begin
         if (out_valid) begin
            if (exp_q.size() > 0) begin
               check("drain_word", {31'd0, out_last, out_data}, {31'd0, exp_q[0]});
               void'(exp_q.pop_front());
            end else begin
               check("drain_extra", {31'd0, out_last, out_data}, 64'hDEAD);
            end
            got++;
         end
         tick();
         cyc++;
      end
      check("drain_count", 64'(got), 64'(n));
   endtask

   initial begin
      logic [31:0] held;
      logic        held_last, stall;
      int          cyc, k;
      rst = 1'b1; written = 1'b0; out_ready = 1'b0; x = '0; y = '0; binary_string = '0;
      tick();
      written = 1'b1;
      tick();
      written = 1'b0;
      check("rst_valid", 64'(out_valid), 0);
      check("rst_data", 64'(out_data), 0);
      check("rst_last", 64'(out_last), 0);
      check("rst_ovf", 64'(overflow), 0);
      check("rst_drop", 64'(drop_cnt), 0);
      check("rst_level", 64'(fifo_level), 0);
      rst = 1'b0;
      tick();
      check("rst_written_ignored", 64'(fifo_level), 0);

      // Single descriptor, ready held high
      out_ready = 1'b1;
      push_desc(11'd100, 11'd50,
                256'h0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF, 1'b1);
      check("single_level_n1", 64'(fifo_level), 1);
      check("single_valid_n1", 64'(out_valid), 0);
      tick();
      check("single_valid_n2", 64'(out_valid), 1);
      check("single_hdr_n2", 64'(out_data), 64'h0001_9064);
      drain(F);
      check("single_idle", 64'(out_valid), 0);
      check("single_level_end", 64'(fifo_level), 0);

      // Back-pressure: ready toggles starting low on the first header cycle
      out_ready = 1'b0;
      push_desc(11'd7, 11'd9, mk_str(3), 1'b1);
      tick();
      check("bp_hdr_up", 64'(out_valid), 1);
      cyc = 0; k = 0;
      while (k < F && cyc < 4 * F) begin
         out_ready = cyc[0];
         stall = 1'b0;
         if (out_valid && out_ready) begin
            check("bp_word", {31'd0, out_last, out_data}, {31'd0, exp_q[0]});
            void'(exp_q.pop_front());
            k++;
         end else begin
            stall = out_valid; held = out_data; held_last = out_last;
         end
         tick();
         cyc++;
         if (stall) check("bp_hold", {30'd0, out_valid, out_last, out_data}, {30'd0, 1'b1, held_last, held});
      end
      check("bp_cycles", 64'(cyc), 64'(2 * F));
      check("bp_idle", 64'(out_valid), 0);

      // Overflow: six pulses with ready low after a fresh reset
      out_ready = 1'b0;
      rst = 1'b1; tick(); rst = 1'b0;
      seq_m = 0; exp_q.delete();
      for (int i = 0; i < 6; i++)
         push_desc(11'(i + 1), 11'(i * 3 + 2), mk_str(i + 10), i < 4);
      check("ovf_level", 64'(fifo_level), 4);
      check("ovf_flag", 64'(overflow), 1);
      check("ovf_drop", 64'(drop_cnt), 2);
      drain(4 * F);
      check("ovf_level_end", 64'(fifo_level), 0);
      check("ovf_idle", 64'(out_valid), 0);

      // Full FIFO with a push coinciding with the tail-word handshake
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_desc(11'(200 + i), 11'(300 + i), mk_str(i + 40), 1'b1);
      check("full_level", 64'(fifo_level), 4);
      drain(F - 1);
      check("full_tail_last", 64'(out_last), 1);
      check("full_tail_word", {31'd0, out_last, out_data}, {31'd0, exp_q[0]});
      void'(exp_q.pop_front());
      push_desc(11'd1234 - 11'd1000, 11'd77, mk_str(99), 1'b1);
      check("full_pop_level", 64'(fifo_level), 4);
      check("full_pop_drop", 64'(drop_cnt), 2);
      check("full_pop_ovf", 64'(overflow), 1);
      drain(4 * F);
      check("full_level_end", 64'(fifo_level), 0);

      // Reset after the third payload word is accepted
      push_desc(11'd5, 11'd6, mk_str(60), 1'b1);
      drain(4);
      rst = 1'b1; written = 1'b1;
      tick();
      written = 1'b0;
      check("mrst_valid", 64'(out_valid), 0);
      check("mrst_level", 64'(fifo_level), 0);
      rst = 1'b0;
      exp_q.delete(); seq_m = 0;
      tick();
      check("mrst_valid_after", 64'(out_valid), 0);
      check("mrst_level_after", 64'(fifo_level), 0);
      push_desc(11'd33, 11'd44, mk_str(70), 1'b1);
      drain(F);

`ifdef DESC_CHECKSUM_EN
      out_ready = 1'b1;
      push_desc(11'd1, 11'd2, {8{32'hFFFFFFFF}}, 1'b1);
      tick();
      for (int i = 0; i < F - 1; i++) tick();
      check("chk_word", {30'd0, out_valid, out_last, out_data}, {30'd0, 1'b1, 1'b1, 32'h0});
      tick();
      exp_q.delete();
      check("chk_idle", 64'(out_valid), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
